prbs_symbol_packer: RTL and testbench
=====================================

Name: prbs_symbol_packer

Overview:
- Downstream consumer of the 5-bit PRBS generator. Takes the serial PRBS bit (generator bit 0) on qualified strobes and packs it into 1-4 bit modulation symbols (BPSK/QPSK/8PSK/16QAM).
- Optionally Gray-codes each symbol.
- Delivers symbols through a 2-entry valid/ready buffer to the constellation mapper / visualization stage.
- The PRBS source cannot stall, so bits arriving when the buffer cannot take a completed symbol are dropped and flagged.

Parameters:
- FIFO_DEPTH, 2, output buffer entries; legal values 2 or 4 (power of two).
- CNT_W, 16, width of the emitted-symbol counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- bit_in  in  1  serial PRBS bit (generator bit 0).
- bit_valid  in  1  qualifies bit_in for one cycle (symbol-rate clock enable).
- mode  in  2  0=BPSK(K=1), 1=QPSK(K=2), 2=8PSK(K=3), 3=16QAM(K=4).
- gray_en  in  1  1 = output the Gray code of the packed word.
- sym_data  out  4  symbol, right-justified; unused MSBs are 0.
- sym_k  out  3  bits-per-symbol of sym_data (1..4).
- sym_valid  out  1  buffer head valid.
- sym_ready  in  1  downstream accepts the head when sym_valid && sym_ready.
- overrun  out  1  sticky: a completed symbol was dropped.
- clr_ovf  in  1  synchronous clear of overrun.
- sym_count  out  CNT_W  symbols pushed into the buffer; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst=1) clears the following, effective immediately:
  - sym_valid=0, sym_data=0, sym_k=1, overrun=0, sym_count=0.
  - Bit counter=0, shift register=0, FIFO pointers=0.
  - Active mode=BPSK, active gray=0.
  - Any in-flight symbol is discarded.
- Mode latch:
  - mode/gray_en are sampled into the active registers only when the bit counter is 0 and bit_valid=1 (the first bit of a symbol).
  - Changes mid-symbol are ignored until the next boundary.
  - The first bit of each symbol always uses the newly sampled K.
- Packing is MSB-first: the first bit received becomes bit K-1 of the symbol.
  - On each bit_valid: shift = {shift[2:0], bit_in}, cnt += 1.
- Symbol completion:
  - Occurs when bit_valid=1 and cnt==K-1.
  - Word = shift with the new bit; Gray option is word ^ (word>>1) over K bits.
  - The word is pushed into the FIFO with its K.
  - cnt returns to 0 in the same cycle.
- Latency: the symbol is visible on sym_data with sym_valid=1 on the first clock edge after the cycle carrying its last bit, if the FIFO was empty.
- Output rules:
  - sym_data/sym_k reflect the FIFO head and are stable while sym_valid && !sym_ready.
  - sym_valid must not drop without a handshake.
- FIFO full:
  - A completed symbol is dropped and overrun is set.
  - sym_count does not increment; the packer restarts at cnt=0.
- Simultaneous pop and push when full: the pop frees a slot and the push is accepted, with no overrun.
- Simultaneous push and pop when empty: the push wins. The FIFO does not bypass, so sym_valid rises on the next cycle.
- clr_ovf together with a new overrun event in the same cycle: overrun ends at 1 (set wins).
- sym_count increments on each accepted push and wraps from 2^CNT_W-1 to 0.
- bit_valid during rst is ignored.

Decomposition:
- Shared package holds:
  - mod_mode_t enum (MODE_BPSK, MODE_QPSK, MODE_8PSK, MODE_16QAM).
  - Constant function/table mode_to_k().
  - MAX_SYM_W = 4.
  - These are reused by the constellation mapper.
- One natural sub-module: sym_fifo, a FIFO_DEPTH x 7-bit synchronous FIFO (4-bit data + 3-bit k) with push/pop/full/empty.
- Packer, Gray encode and counters stay in the top.

Test Plan:
1. Reset mid-symbol: in QPSK, feed one bit then assert rst for 1 cycle, then feed bits 1,0 -> exactly one symbol, sym_data=4'b0010, sym_k=2, with no stale bit from before reset.
2. 16QAM binary: mode=3, gray_en=0, bits 1,0,1,1 with sym_ready=1 -> sym_data=4'b1011, sym_k=4, sym_valid for 1 cycle starting 1 cycle after the 4th bit, sym_count=1.
3. 8PSK Gray: mode=2, gray_en=1, bits 1,1,0 -> binary 110 -> sym_data=4'b0101, sym_k=3.
4. Mode change mid-symbol: mode=1, feed bit 1; switch mode=0; feed bit 1 -> QPSK symbol 2'b11. Next bit 0 -> BPSK symbol 0, sym_k=1.
5. Overrun: BPSK, sym_ready=0, 3 bits 1,0,1 (FIFO_DEPTH=2) -> FIFO holds 1 then 0, overrun=1, sym_count=2. Raise sym_ready -> outputs 1 then 0, then sym_valid=0. clr_ovf -> overrun=0.
6. Full with pop and push in the same cycle: FIFO full, sym_ready=1 on the cycle the 3rd symbol completes -> no overrun, sym_count=3, all three symbols emitted in order. Separately, preset sym_count to 16'hFFFF via 65535 BPSK symbols; the next symbol reads 0.

Source files
------------

// File: rtl/prbs_symbol_packer_pkg.sv
// prbs_symbol_packer_pkg
// Shared definitions for the PRBS symbol path. The packer and the
// constellation mapper both use these.
//   mod_mode_t  : modulation selector (BPSK/QPSK/8PSK/16QAM)
//   mode_to_k() : bits per symbol for each modulation
//   sym_mask()  : keeps only the low K bits of a packed word
//   MAX_SYM_W   : widest symbol (16QAM); K_W : width of a K value
//   ENTRY_W     : width of one buffered entry, {k, data}
package prbs_symbol_packer_pkg;

    localparam int MAX_SYM_W = 4;
    localparam int K_W       = 3;
    localparam int ENTRY_W   = MAX_SYM_W + K_W;

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'd0,
        MODE_QPSK  = 2'd1,
        MODE_8PSK  = 2'd2,
        MODE_16QAM = 2'd3
    } mod_mode_t;

    function automatic logic [K_W-1:0] mode_to_k(input mod_mode_t m);
        case (m)
            MODE_BPSK:  return 3'd1;
            MODE_QPSK:  return 3'd2;
            MODE_8PSK:  return 3'd3;
            MODE_16QAM: return 3'd4;
            default:    return 3'd1;
        endcase
    endfunction

    function automatic logic [MAX_SYM_W-1:0] sym_mask(input logic [K_W-1:0] k);
        case (k)
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/prbs_symbol_packer_fifo.sv
// sym_fifo
// DEPTH x WIDTH synchronous FIFO that holds completed symbols ({k, data}).
// The head is read combinationally; nothing bypasses the storage, so a word
// written into an empty FIFO shows up one clock later.
//   clk, rst     : clock, asynchronous active-high reset
//   push, i_data : write request and the word to write
//   pop          : read request (ignored while empty)
//   o_data       : current head word
//   full, empty  : occupancy flags
//   push_ok      : push is accepted this cycle (a pop on a full FIFO frees a slot)
module sym_fifo
    import prbs_symbol_packer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             pop,
    output logic [WIDTH-1:0] o_data,
    output logic             full,
    output logic             empty,
    output logic             push_ok
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_pop;

    // The pointers carry one extra wrap bit so that full and empty can be told apart.
    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop = pop && !empty;
    assign push_ok  = push && (!full || w_do_pop);
    assign o_data   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push_ok)  r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // The storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/prbs_symbol_packer.sv
// prbs_symbol_packer
// Packs the serial PRBS bit into 1..4-bit modulation symbols, MSB first.
// Each symbol can be Gray-coded. Symbols go out through a small valid/ready
// buffer. The PRBS source cannot stall, so if a symbol completes while the
// buffer is full, that symbol is dropped and a sticky overrun flag is set.
//   clk, rst              : clock, asynchronous active-high reset
//   bit_in, bit_valid     : serial PRBS bit and its one-cycle qualifier
//   mode, gray_en         : modulation and Gray select, latched at each symbol start
//   sym_data, sym_k       : buffer head, right-justified, and its bits-per-symbol
//   sym_valid, sym_ready  : output handshake
//   overrun, clr_ovf      : sticky drop flag and its synchronous clear
//   sym_count             : count of symbols accepted into the buffer (wraps)
module prbs_symbol_packer
    import prbs_symbol_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic [1:0]           mode,
    input  logic                 gray_en,
    output logic [MAX_SYM_W-1:0] sym_data,
    output logic [K_W-1:0]       sym_k,
    output logic                 sym_valid,
    input  logic                 sym_ready,
    output logic                 overrun,
    input  logic                 clr_ovf,
    output logic [CNT_W-1:0]     sym_count
);
    logic [1:0]           r_cnt;
    logic [2:0]           r_shift;
    mod_mode_t            r_mode;
    logic                 r_gray;
    logic                 r_overrun;
    logic [CNT_W-1:0]     r_sym_count;

    logic                 w_first;
    mod_mode_t            w_mode;
    logic                 w_gray;
    logic [K_W-1:0]       w_k;
    logic                 w_done;
    logic [MAX_SYM_W-1:0] w_raw;
    logic [MAX_SYM_W-1:0] w_word;
    logic [MAX_SYM_W-1:0] w_sym;
    logic [ENTRY_W-1:0]   w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push_ok;

    // On the first bit of a symbol, the incoming mode and gray_en take effect
    // in that same cycle. Later bits use the values latched at that first bit.
    assign w_first = bit_valid && (r_cnt == 2'd0);
    assign w_mode  = w_first ? mod_mode_t'(mode) : r_mode;
    assign w_gray  = w_first ? gray_en : r_gray;
    assign w_k     = mode_to_k(w_mode);
    assign w_done  = bit_valid && ({1'b0, r_cnt} == (w_k - 3'd1));

    // Bits left over from earlier symbols sit above bit K-1, so masking
    // removes them. The Gray shift then brings in only zeros.
    assign w_raw   = {r_shift, bit_in};
    assign w_word  = w_raw & sym_mask(w_k);
    assign w_sym   = w_gray ? (w_word ^ (w_word >> 1)) : w_word;

    sym_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_done),
        .i_data  ({w_k, w_sym}),
        .pop     (sym_ready),
        .o_data  (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .push_ok (w_push_ok)
    );

    // Bit counter, shift register and latched mode. After a completion the
    // counter goes back to 0, whether or not the buffer took the symbol.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 2'd0;
            r_shift <= 3'd0;
            r_mode  <= MODE_BPSK;
            r_gray  <= 1'b0;
        end else begin
            if (bit_valid) begin
                r_shift <= w_raw[2:0];
                r_cnt   <= w_done ? 2'd0 : r_cnt + 2'd1;
            end
            if (w_first) begin
                r_mode <= mod_mode_t'(mode);
                r_gray <= gray_en;
            end
        end
    end

    // Status: counts accepted symbols and keeps the drop flag. If a drop and
    // clr_ovf happen in the same cycle, the flag stays set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun   <= 1'b0;
            r_sym_count <= '0;
        end else begin
            if (w_push_ok)
                r_sym_count <= r_sym_count + CNT_W'(1);
            if (w_done && !w_push_ok)
                r_overrun <= 1'b1;
            else if (clr_ovf)
                r_overrun <= 1'b0;
        end
    end

    // An empty buffer shows the reset values rather than stale storage.
    assign sym_valid = !w_empty;
    assign sym_data  = w_empty ? '0 : w_head[MAX_SYM_W-1:0];
    assign sym_k     = w_empty ? 3'd1 : w_head[ENTRY_W-1:MAX_SYM_W];
    assign overrun   = r_overrun;
    assign sym_count = r_sym_count;

endmodule

// File: tb/tb_prbs_symbol_packer.sv
// tb_prbs_symbol_packer
// Drives bit sequences into prbs_symbol_packer. Expected symbols come from a
// small reference model and wait in a queue until the DUT presents them.
// Each scenario task does its own comparisons.
module tb_prbs_symbol_packer;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 16;

    logic             clk;
    logic             rst;
    logic             bit_in;
    logic             bit_valid;
    logic [1:0]       mode;
    logic             gray_en;
    logic [3:0]       sym_data;
    logic [2:0]       sym_k;
    logic             sym_valid;
    logic             sym_ready;
    logic             overrun;
    logic             clr_ovf;
    logic [CNT_W-1:0] sym_count;

    int passCount = 0;
    int checkCount = 0;
    logic [6:0] expQ [$];

    prbs_symbol_packer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .mode      (mode),
        .gray_en   (gray_en),
        .sym_data  (sym_data),
        .sym_k     (sym_k),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .overrun   (overrun),
        .clr_ovf   (clr_ovf),
        .sym_count (sym_count)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stops a hung run.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: keep the low k bits of the MSB-first word, then Gray-code if asked.
    function automatic logic [6:0] modelSym(input logic [3:0] word, input int k, input logic g);
        logic [3:0] w;
        w = word & 4'((1 << k) - 1);
        if (g) w = w ^ (w >> 1);
        return {3'(k), w};
    endfunction

    // Every step ends 1 time unit after a rising edge, so inputs are
    // driven and outputs sampled away from the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; sym_ready = 1'b0;
        clr_ovf = 1'b0; mode = 2'd0; gray_en = 1'b0;
        tick;
        rst = 1'b0;
        expQ.delete();
    endtask

    task automatic applyStimulus(input logic b);
        bit_in = b; bit_valid = 1'b1;
        tick;
        bit_valid = 1'b0;
    endtask

    task automatic sendSymbol(input logic [3:0] word, input int k);
        for (int i = k - 1; i >= 0; i--) applyStimulus(word[i]);
    endtask

    // Reset is asynchronous: outputs clear with no clock edge.
    task automatic test_reset;
        doReset;
        applyStimulus(1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkCount++; if (sym_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", sym_valid); else passCount++;
        checkCount++; if (sym_data !== 4'd0) $display("[TB] FAIL reset_data: got %h want 0", sym_data); else passCount++;
        checkCount++; if (sym_k !== 3'd1) $display("[TB] FAIL reset_k: got %0d want 1", sym_k); else passCount++;
        checkCount++; if (overrun !== 1'b0) $display("[TB] FAIL reset_ovf: got %b want 0", overrun); else passCount++;
        checkCount++; if (sym_count !== '0) $display("[TB] FAIL reset_count: got %0d want 0", sym_count); else passCount++;
        tick;
        rst = 1'b0;
    endtask

    // A bit that was in flight before reset, or that arrived during reset, leaves nothing behind.
    task automatic test_reset_mid_symbol;
        logic [6:0] expSym;
        doReset;
        mode = 2'd1;
        applyStimulus(1'b1);
        rst = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
        tick;
        bit_valid = 1'b0; rst = 1'b0;
        applyStimulus(1'b1);
        checkCount++; if (sym_valid !== 1'b0) $display("[TB] FAIL rstmid_early: got valid %b want 0", sym_valid); else passCount++;
        applyStimulus(1'b0);
        expQ.push_back(modelSym(4'b0010, 2, 1'b0));
        expSym = expQ.pop_front();
        checkCount++; if (!sym_valid || {sym_k, sym_data} !== expSym) $display("[TB] FAIL rstmid_sym: got v=%b %h want %h", sym_valid, {sym_k, sym_data}, expSym); else passCount++;
        checkCount++; if (sym_count !== 16'd1) $display("[TB] FAIL rstmid_count: got %0d want 1", sym_count); else passCount++;
        sym_ready = 1'b1;
        tick;
        sym_ready = 1'b0;
        checkCount++; if (sym_valid !== 1'b0) $display("[TB] FAIL rstmid_single: got valid %b want 0", sym_valid); else passCount++;
    endtask

    // 16QAM binary: the symbol appears one edge after its last bit and stays for one cycle.
    task automatic test_16qam;
        logic [6:0] expSym;
        doReset;
        mode = 2'd3; sym_ready = 1'b1;
        sendSymbol(4'b1011, 4);
        expQ.push_back(modelSym(4'b1011, 4, 1'b0));
        expSym = expQ.pop_front();
        checkCount++; if (!sym_valid || {sym_k, sym_data} !== expSym) $display("[TB] FAIL qam_sym: got v=%b %h want %h", sym_valid, {sym_k, sym_data}, expSym); else passCount++;
        checkCount++; if (sym_count !== 16'd1) $display("[TB] FAIL qam_count: got %0d want 1", sym_count); else passCount++;
        tick;
        checkCount++; if (sym_valid !== 1'b0) $display("[TB] FAIL qam_onecycle: got valid %b want 0", sym_valid); else passCount++;
        sym_ready = 1'b0;
    endtask

    // Gray coding in 8PSK and 16QAM. Both symbols are buffered and then drained.
    task automatic test_gray;
        logic [6:0] expSym;
        doReset;
        gray_en = 1'b1; mode = 2'd2;
        sendSymbol(4'b0110, 3);
        expQ.push_back(modelSym(4'b0110, 3, 1'b1));
        mode = 2'd3;
        sendSymbol(4'b1011, 4);
        expQ.push_back(modelSym(4'b1011, 4, 1'b1));
        tick;
        sym_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            expSym = expQ.pop_front();
            checkCount++; if (!sym_valid || {sym_k, sym_data} !== expSym) $display("[TB] FAIL gray_sym%0d: got v=%b %h want %h", i, sym_valid, {sym_k, sym_data}, expSym); else passCount++;
            tick;
        end
        sym_ready = 1'b0;
        checkCount++; if (sym_valid !== 1'b0) $display("[TB] FAIL gray_empty: got valid %b want 0", sym_valid); else passCount++;
    endtask

    // mode and gray_en changes in the middle of a symbol wait for the next boundary.
    task automatic test_mode_change;
        logic [6:0] expSym;
        doReset;
        mode = 2'd1; gray_en = 1'b0;
        applyStimulus(1'b1);
        mode = 2'd0; gray_en = 1'b1;
        applyStimulus(1'b1);
        expQ.push_back(modelSym(4'b0011, 2, 1'b0));
        gray_en = 1'b0;
        applyStimulus(1'b0);
        expQ.push_back(modelSym(4'b0000, 1, 1'b0));
        sym_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            expSym = expQ.pop_front();
            checkCount++; if (!sym_valid || {sym_k, sym_data} !== expSym) $display("[TB] FAIL mode_sym%0d: got v=%b %h want %h", i, sym_valid, {sym_k, sym_data}, expSym); else passCount++;
            tick;
        end
        sym_ready = 1'b0;
    endtask

    // Overrun: a drop when the buffer is full, set winning over clr_ovf, and stable head data.
    task automatic test_overrun;
        logic [6:0] expSym;
        doReset;
        applyStimulus(1'b1); expQ.push_back(modelSym(4'b0001, 1, 1'b0));
        applyStimulus(1'b0); expQ.push_back(modelSym(4'b0000, 1, 1'b0));
        checkCount++; if (overrun !== 1'b0) $display("[TB] FAIL ovf_early: got %b want 0", overrun); else passCount++;
        applyStimulus(1'b1);
        checkCount++; if (overrun !== 1'b1) $display("[TB] FAIL ovf_set: got %b want 1", overrun); else passCount++;
        checkCount++; if (sym_count !== 16'd2) $display("[TB] FAIL ovf_count: got %0d want 2", sym_count); else passCount++;
        clr_ovf = 1'b1;
        applyStimulus(1'b1);
        clr_ovf = 1'b0;
        checkCount++; if (overrun !== 1'b1) $display("[TB] FAIL ovf_setwins: got %b want 1", overrun); else passCount++;
        tick;
        sym_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            expSym = expQ.pop_front();
            checkCount++; if (!sym_valid || {sym_k, sym_data} !== expSym) $display("[TB] FAIL ovf_sym%0d: got v=%b %h want %h", i, sym_valid, {sym_k, sym_data}, expSym); else passCount++;
            tick;
        end
        sym_ready = 1'b0;
        checkCount++; if (sym_valid !== 1'b0) $display("[TB] FAIL ovf_empty: got valid %b want 0", sym_valid); else passCount++;
        checkCount++; if (overrun !== 1'b1) $display("[TB] FAIL ovf_sticky: got %b want 1", overrun); else passCount++;
        clr_ovf = 1'b1;
        tick;
        clr_ovf = 1'b0;
        checkCount++; if (overrun !== 1'b0) $display("[TB] FAIL ovf_clear: got %b want 0", overrun); else passCount++;
    endtask

    // Full buffer: a pop and a push in the same cycle are both accepted and nothing is lost.
    task automatic test_back_to_back;
        logic [6:0] expSym;
        doReset;
        applyStimulus(1'b1); expQ.push_back(modelSym(4'b0001, 1, 1'b0));
        applyStimulus(1'b0); expQ.push_back(modelSym(4'b0000, 1, 1'b0));
        sym_ready = 1'b1;
        expSym = expQ.pop_front();
        checkCount++; if (!sym_valid || {sym_k, sym_data} !== expSym) $display("[TB] FAIL b2b_head: got v=%b %h want %h", sym_valid, {sym_k, sym_data}, expSym); else passCount++;
        applyStimulus(1'b1); expQ.push_back(modelSym(4'b0001, 1, 1'b0));
        checkCount++; if (overrun !== 1'b0) $display("[TB] FAIL b2b_ovf: got %b want 0", overrun); else passCount++;
        checkCount++; if (sym_count !== 16'd3) $display("[TB] FAIL b2b_count: got %0d want 3", sym_count); else passCount++;
        for (int i = 0; i < 2; i++) begin
            expSym = expQ.pop_front();
            checkCount++; if (!sym_valid || {sym_k, sym_data} !== expSym) $display("[TB] FAIL b2b_sym%0d: got v=%b %h want %h", i, sym_valid, {sym_k, sym_data}, expSym); else passCount++;
            tick;
        end
        sym_ready = 1'b0;
        checkCount++; if (sym_valid !== 1'b0) $display("[TB] FAIL b2b_empty: got valid %b want 0", sym_valid); else passCount++;
    endtask

    // Symbol counter wraps from all ones back to zero.
    task automatic test_count_wrap;
        logic [6:0] expSym;
        doReset;
        sym_ready = 1'b1; bit_in = 1'b0; bit_valid = 1'b1;
        repeat (65535) tick;
        bit_valid = 1'b0;
        checkCount++; if (sym_count !== 16'hFFFF) $display("[TB] FAIL wrap_max: got %h want ffff", sym_count); else passCount++;
        checkCount++; if (overrun !== 1'b0) $display("[TB] FAIL wrap_ovf: got %b want 0", overrun); else passCount++;
        applyStimulus(1'b1);
        expQ.push_back(modelSym(4'b0001, 1, 1'b0));
        checkCount++; if (sym_count !== 16'h0000) $display("[TB] FAIL wrap_zero: got %h want 0000", sym_count); else passCount++;
        expSym = expQ.pop_front();
        checkCount++; if (!sym_valid || {sym_k, sym_data} !== expSym) $display("[TB] FAIL wrap_sym: got v=%b %h want %h", sym_valid, {sym_k, sym_data}, expSym); else passCount++;
        tick;
        sym_ready = 1'b0;
    endtask

    // Run all scenarios in order, then print the summary.
    initial begin
        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; sym_ready = 1'b0;
        clr_ovf = 1'b0; mode = 2'd0; gray_en = 1'b0;
        test_reset;
        test_reset_mid_symbol;
        test_16qam;
        test_gray;
        test_mode_change;
        test_overrun;
        test_back_to_back;
        test_count_wrap;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
